icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the IF stage and the AXI refill controller. Hits return the addressed word in the lookup cycle with no stall. A miss stalls the pipeline, requests a full 8-word line over the `icache_miss`/`icache_addr` pair, writes the returned `icache_cacheline` into the arrays, then retries the lookup.

## Interface
- `INDEX_WIDTH`, 6: line index bits; the cache has 2^INDEX_WIDTH lines.
- `CACHELINE_WIDTH`, 256: line width in bits, fixed at 8 words. This matches the codebase `CACHELINE_WIDTH` define.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `inst_sram_en`, in, 1: fetch request this cycle.
- `inst_sram_addr`, in, 32: fetch byte address, word aligned. Held stable by IF while `stallreq`=1.
- `inst_rdata`, out, 32: fetched instruction, valid when `inst_sram_en`=1 and `stallreq`=0.
- `stallreq`, out, 1: pipeline stall request.
- `icache_miss`, out, 1: refill request level to the AXI controller.
- `icache_addr`, out, 32: line-aligned refill address, `{addr[31:5],5'b0}`.
- `icache_refresh`, in, 1: refill-data-valid level from the AXI controller.
- `icache_cacheline`, in, 256: refill data; word w is `[w*32+:32]`.

## Operation
- Address split:
  - offset is `[4:0]`; word select is `[4:2]`.
  - index is `[4+INDEX_WIDTH:5]`.
  - tag is `[31:5+INDEX_WIDTH]`.
- Storage is flops:
  - valid bits, 2^INDEX_WIDTH × 1;
  - tag array, 2^INDEX_WIDTH × (27-INDEX_WIDTH);
  - data array, 2^INDEX_WIDTH × 256.
- hit = `valid[index] && tag[index]==addr tag`.
- FSM, one-hot, three states:
  - LOOKUP
    - `en`=0: `stallreq`=0, `inst_rdata`=0.
    - `en`=1 with a hit: `inst_rdata` = the selected word, `stallreq`=0.
    - `en`=1 with a miss: `stallreq`=1; register `icache_addr`; go to MISS.
  - MISS
    - `icache_miss`=1 and `stallreq`=1.
    - On `icache_refresh`=1: write data, tag and valid=1 at the miss index; drop `icache_miss` the next cycle; go to DONE.
  - DONE
    - `stallreq`=1 and `icache_miss`=0.
    - Stay until `icache_refresh`=0, then go to LOOKUP.
    - The retried lookup hits.
- `icache_refresh` is a level and is held for several cycles by the controller. Only the first cycle seen in MISS writes. DONE guarantees no double write and no re-issue while refresh is still high.
- `icache_miss` is never asserted in the same cycle as `icache_refresh`, except in the MISS capture cycle.
- Reset is synchronous. It is honoured in any state, including mid-refill:
  - state goes to LOOKUP;
  - all valid bits clear;
  - `icache_miss`=0 and `icache_addr`=0.
  - `stallreq` and `inst_rdata` are combinational; with `en`=0 both are 0.
  - Tag and data arrays are not reset.

## Timing
- Hit: zero added latency. `inst_rdata` and `stallreq`=0 are valid combinationally in the request cycle.
- Miss, with the detect cycle as T0:
  - T1: state MISS, `icache_miss`=1, `icache_addr` valid.
  - Refresh first seen in cycle R: the line is written at the end of R.
  - R+1: DONE.
  - First cycle F with refresh low: DONE → LOOKUP at the end of F.
  - F+1: hit, `stallreq`=0.
- `stallreq` is 1 continuously from T0 through F.
- `icache_addr` is stable from T1 until the next miss.

## Configuration
- `ICACHE_PERF_EN` defined:
  - adds outputs `perf_hit_cnt` [31:0] and `perf_miss_cnt` [31:0], both reset to 0;
  - hit count increments on each LOOKUP hit with `en`=1;
  - miss count increments on each LOOKUP → MISS transition;
  - both counters wrap at 2^32.
- `ICACHE_PERF_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then `en`=1, `addr`=0xBFC00000:
  - `stallreq`=1 and the next cycle `icache_miss`=1, `icache_addr`=0xBFC00000.
  - Refresh with word0=0x3C080001 held 2 cycles.
  - Exactly one write, then a hit returns 0x3C080001 with `stallreq`=0.
- After that fill, `addr`=0xBFC0001C:
  - hits the same line with no stall;
  - returns word 7 of the line.
- Conflict on index 0:
  - fill 0xBFC00000, then fetch 0xBFC00800 (same index, different tag);
  - the fetch misses and evicts; refetching 0xBFC00000 misses again.
- `icache_refresh` held high 3 cycles:
  - exactly one array write;
  - `icache_miss` stays 0 until refresh drops;
  - there is no second request.
- `rst` asserted in MISS:
  - next cycle `icache_miss`=0, state LOOKUP;
  - the previous fill is lost, so refetching 0xBFC00000 misses.
- With `ICACHE_PERF_EN`, the sequence miss, hit, hit gives `perf_miss_cnt`=1 and `perf_hit_cnt`=2.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-line refill handshake.
// Optional ICACHE_PERF_EN adds hit/miss performance counters.
module icache #(
    parameter int unsigned INDEX_WIDTH     = 6,
    parameter int unsigned CACHELINE_WIDTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inst_sram_en,
    input  logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_rdata,
    output logic                       stallreq,
    output logic                       icache_miss,
    output logic [31:0]                icache_addr,
    input  logic                       icache_refresh,
    input  logic [CACHELINE_WIDTH-1:0] icache_cacheline
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                perf_hit_cnt,
    output logic [31:0]                perf_miss_cnt
`endif
);

    localparam int unsigned LINES     = 1 << INDEX_WIDTH;
    localparam int unsigned TAG_WIDTH = 27 - INDEX_WIDTH;

    typedef enum logic [2:0] {
        ST_LOOKUP = 3'b001,
        ST_MISS   = 3'b010,
        ST_DONE   = 3'b100
    } state_e;

    state_e                     state_q, state_d;
    logic                       miss_q, miss_d;
    logic [26:0]                line_q, line_d;
    logic [LINES-1:0]           valid_q, valid_d;
    logic [TAG_WIDTH-1:0]       tag_q  [LINES];
    logic [CACHELINE_WIDTH-1:0] data_q [LINES];

    logic [INDEX_WIDTH-1:0]     req_idx, fill_idx;
    logic [TAG_WIDTH-1:0]       req_tag, fill_tag;
    logic [2:0]                 req_word;
    logic [CACHELINE_WIDTH-1:0] sel_line;
    logic                       hit, fill_wr, hit_inc, miss_inc;
    logic                       addr_lsb_unused;

    assign req_idx         = inst_sram_addr[4+INDEX_WIDTH:5];
    assign req_tag         = inst_sram_addr[31:5+INDEX_WIDTH];
    assign req_word        = inst_sram_addr[4:2];
    assign addr_lsb_unused = ^inst_sram_addr[1:0];
    assign sel_line        = data_q[req_idx];
    assign hit             = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Fill location comes from the captured miss line, not the live fetch address.
    assign fill_idx    = line_q[INDEX_WIDTH-1:0];
    assign fill_tag    = line_q[26:INDEX_WIDTH];
    assign icache_miss = miss_q;
    assign icache_addr = {line_q, 5'b0};

    always_comb begin
        state_d    = state_q;
        miss_d     = miss_q;
        line_d     = line_q;
        stallreq   = 1'b0;
        inst_rdata = '0;
        fill_wr    = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        unique case (state_q)
            ST_LOOKUP: begin
                if (inst_sram_en) begin
                    if (hit) begin
                        inst_rdata = sel_line[{req_word, 5'b0} +: 32];
                        hit_inc    = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                        miss_d   = 1'b1;
                        line_d   = inst_sram_addr[31:5];
                        miss_inc = 1'b1;
                        state_d  = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                stallreq = 1'b1;
                if (icache_refresh) begin
                    fill_wr = 1'b1;
                    miss_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Wait out the refresh level so it cannot trigger a second write.
                stallreq = 1'b1;
                if (!icache_refresh) begin
                    state_d = ST_LOOKUP;
                end
            end
            default: state_d = ST_LOOKUP;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (fill_wr) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOOKUP;
            miss_q  <= 1'b0;
            line_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            line_q  <= line_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= icache_cacheline;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'(hit_inc);
        miss_cnt_d = miss_cnt_q + 32'(miss_inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`else
    logic perf_unused;
    assign perf_unused = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: acts as IF stage and refill controller, checks
// against a direct-mapped line model kept as plain arrays.
module tb_icache;

    logic         clk = 1'b0;
    logic         rst, inst_sram_en, icache_refresh;
    logic [31:0]  inst_sram_addr, inst_rdata, icache_addr;
    logic         stallreq, icache_miss;
    logic [255:0] icache_cacheline;
`ifdef ICACHE_PERF_EN
    logic [31:0]  perf_hit_cnt, perf_miss_cnt;
`endif

    always #5 clk = ~clk;

    icache dut (
        .clk              (clk),
        .rst              (rst),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_addr   (inst_sram_addr),
        .inst_rdata       (inst_rdata),
        .stallreq         (stallreq),
        .icache_miss      (icache_miss),
        .icache_addr      (icache_addr),
        .icache_refresh   (icache_refresh),
        .icache_cacheline (icache_cacheline)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit_cnt     (perf_hit_cnt),
        .perf_miss_cnt    (perf_miss_cnt)
`endif
    );

    // Reference: which memory line each slot holds, and that line's words.
    bit          mvalid [64];
    bit [20:0]   mtag   [64];
    bit [31:0]   mdata  [64][8];
    int unsigned m_hits, m_miss;
    int          n_cmp, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        inst_sram_en   = 1'b0;
        inst_sram_addr = $urandom;
        @(negedge clk);
        check("idle_stall", 32'(stallreq), 32'd0);
        check("idle_rdata", inst_rdata, 32'd0);
        next_cycle();
    endtask

    // Fetch one word; on a miss, play the refill controller with the given
    // wait and refresh-hold lengths, then check the retried hit.
    task automatic fetch(input logic [31:0] a, input int dly, input int hold,
                         input bit force_w0, input logic [31:0] w0, output bit was_miss);
        int unsigned idx  = 32'(a[10:5]);
        int unsigned w    = 32'(a[4:2]);
        bit [20:0]   tg   = a[31:11];
        bit          hit  = mvalid[idx] && (mtag[idx] == tg);
        bit [31:0]   line [8];
        logic [31:0] laddr = {a[31:5], 5'b0};
        inst_sram_en   = 1'b1;
        inst_sram_addr = a;
        @(negedge clk);
        was_miss = stallreq;
        if (hit) begin
            check("hit_stall", 32'(stallreq), 32'd0);
            check("hit_data", inst_rdata, mdata[idx][w]);
            m_hits++;
            next_cycle();
        end else begin
            check("miss_stall", 32'(stallreq), 32'd1);
            m_miss++;
            next_cycle();
            for (int d = 0; d < dly; d++) begin
                @(negedge clk);
                check("wait_miss", 32'(icache_miss), 32'd1);
                check("wait_stall", 32'(stallreq), 32'd1);
                next_cycle();
            end
            for (int k = 0; k < 8; k++) line[k] = $urandom;
            if (force_w0) line[0] = w0;
            for (int k = 0; k < hold; k++) begin
                icache_refresh = 1'b1;
                // Later refresh cycles carry junk so a second write would show.
                for (int j = 0; j < 8; j++)
                    icache_cacheline[j*32 +: 32] = (k == 0) ? line[j] : $urandom;
                @(negedge clk);
                check("refill_addr", icache_addr, laddr);
                check(k == 0 ? "capture_miss" : "hold_miss", 32'(icache_miss), k == 0 ? 32'd1 : 32'd0);
                check("refill_stall", 32'(stallreq), 32'd1);
                next_cycle();
                if (k == 0) begin
                    mvalid[idx] = 1'b1;
                    mtag[idx]   = tg;
                    for (int j = 0; j < 8; j++) mdata[idx][j] = line[j];
                end
            end
            icache_refresh   = 1'b0;
            icache_cacheline = {8{32'hDEADBEEF}};
            @(negedge clk);
            check("drop_stall", 32'(stallreq), 32'd1);
            check("drop_miss", 32'(icache_miss), 32'd0);
            next_cycle();
            @(negedge clk);
            check("retry_stall", 32'(stallreq), 32'd0);
            check("retry_data", inst_rdata, mdata[idx][w]);
            m_hits++;
            next_cycle();
        end
    endtask

    task automatic perf_check();
`ifdef ICACHE_PERF_EN
        check("perf_hits", perf_hit_cnt, m_hits);
        check("perf_miss", perf_miss_cnt, m_miss);
`endif
    endtask

    initial begin
        bit          wm;
        logic [31:0] a;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        inst_sram_en = 1'b0;
        inst_sram_addr = '0;
        icache_refresh = 1'b0;
        icache_cacheline = '0;
        model_reset();
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_miss", 32'(icache_miss), 32'd0);
        check("rst_addr", icache_addr, 32'd0);
        check("rst_stall", 32'(stallreq), 32'd0);
        check("rst_rdata", inst_rdata, 32'd0);
        next_cycle();

        // Boot fetch: cold miss, refresh held 2 cycles, then hit on word 0.
        fetch(32'hBFC00000, 0, 2, 1'b1, 32'h3C080001, wm);
        check("boot_is_miss", 32'(wm), 32'd1);
        @(negedge clk);
        check("boot_word", inst_rdata, 32'h3C080001);
        m_hits++;
        next_cycle();
        fetch(32'hBFC0001C, 0, 1, 1'b0, 0, wm);
        check("word7_no_miss", 32'(wm), 32'd0);

        // Conflict on index 0 evicts the boot line.
        fetch(32'hBFC00800, 1, 1, 1'b0, 0, wm);
        check("conflict_miss", 32'(wm), 32'd1);
        fetch(32'hBFC00000, 0, 1, 1'b0, 0, wm);
        check("evicted_miss", 32'(wm), 32'd1);

        // Long refresh level: one write, no re-request.
        fetch(32'hBFC00020, 1, 3, 1'b0, 0, wm);
        check("hold3_miss", 32'(wm), 32'd1);
        idle_cycle();

        // Reset while waiting in MISS.
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'hBFC00060;
        @(negedge clk);
        check("pre_rst_stall", 32'(stallreq), 32'd1);
        next_cycle();
        @(negedge clk);
        check("pre_rst_miss", 32'(icache_miss), 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        inst_sram_en = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_miss", 32'(icache_miss), 32'd0);
        check("midrst_addr", icache_addr, 32'd0);
        check("midrst_stall", 32'(stallreq), 32'd0);
        next_cycle();
        fetch(32'hBFC00000, 0, 1, 1'b0, 0, wm);
        check("lost_fill_miss", 32'(wm), 32'd1);
        fetch(32'hBFC00004, 0, 1, 1'b0, 0, wm);
        check("after_fill_hit", 32'(wm), 32'd0);
        perf_check();

        // Random traffic over 4 tags x 4 indices.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                a = 32'hBFC00000 + (32'($urandom_range(0, 3)) << 11)
                  + (32'($urandom_range(0, 3)) << 5) + (32'($urandom_range(0, 7)) << 2);
                fetch(a, int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), 1'b0, 0, wm);
            end
        end
        perf_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
